// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and gradient-magnitude helpers for the Sobel datapath
package sobel_pkg;

  typedef enum logic [1:0] {
    MAG_L1   = 2'd0,
    MAG_LINF = 2'd1,
    MAG_AL2  = 2'd2,
    MAG_RSVD = 2'd3
  } mag_mode_e;

  localparam int AL2_SHIFT_A = 2;
  localparam int AL2_SHIFT_B = 3;

  // Helpers work on a wide scratch width; callers cast to their own widths.
  localparam int CALC_W = 32;

  function automatic logic [CALC_W-1:0] abs_val(input logic signed [CALC_W-1:0] x);
    return (x < 0) ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [CALC_W-1:0] mag_metric(input logic [CALC_W-1:0] a,
                                                   input logic [CALC_W-1:0] b,
                                                   input mag_mode_e mode);
    logic [CALC_W-1:0] mx;
    logic [CALC_W-1:0] mn;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    case (mode)
      MAG_LINF: return mx;
      MAG_AL2:  return mx + (mn >> AL2_SHIFT_A) + (mn >> AL2_SHIFT_B);
      default:  return a + b;
    endcase
  endfunction

endpackage

// File: rtl/magnitude_pipe_if.sv
// rtl/magnitude_pipe_if.sv - upstream/downstream handshake bundle for magnitude_pipe
interface magnitude_pipe_if
  import sobel_pkg::*;
#(
  parameter int WIDTH_P     = 8,
  parameter int OUT_WIDTH_P = 8
);
  logic                   valid_i;
  logic                   ready_o;
  logic [WIDTH_P-1:0]     gx_i;
  logic [WIDTH_P-1:0]     gy_i;
  mag_mode_e              mode_i;
  logic [OUT_WIDTH_P-1:0] thresh_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [OUT_WIDTH_P-1:0] mag_o;
  logic                   edge_o;
  logic                   sat_o;

  modport slave (
    input  valid_i, gx_i, gy_i, mode_i, thresh_i, ready_i,
    output ready_o, valid_o, mag_o, edge_o, sat_o
  );

  modport master (
    output valid_i, gx_i, gy_i, mode_i, thresh_i, ready_i,
    input  ready_o, valid_o, mag_o, edge_o, sat_o
  );
endinterface

// File: rtl/elastic_reg.sv
// rtl/elastic_reg.sv - single-entry valid/ready register, accepts on the edge its beat leaves
module elastic_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata
);
  logic         valid_q;
  logic [W-1:0] data_q;

  assign s_tready = !valid_q || m_tready;
  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (s_tready) begin
      valid_q <= s_tvalid;
      if (s_tvalid) data_q <= s_tdata;
    end
  end
endmodule

// File: rtl/magnitude_pipe.sv
// rtl/magnitude_pipe.sv - two-stage elastic gradient magnitude with clamp and edge flag
module magnitude_pipe
  import sobel_pkg::*;
#(
  parameter int WIDTH_P     = 8,
  parameter int OUT_WIDTH_P = 8
) (
  input logic             clk_i,
  input logic             rstn_i,
  magnitude_pipe_if.slave bus
);
  typedef struct packed {
    logic [WIDTH_P-1:0]     a;
    logic [WIDTH_P-1:0]     b;
    mag_mode_e              mode;
    logic [OUT_WIDTH_P-1:0] thresh;
  } s1_t;

  typedef struct packed {
    logic [OUT_WIDTH_P-1:0] mag;
    logic                   edge_flag;
    logic                   sat;
  } s2_t;

  localparam logic [CALC_W-1:0] MAG_MAX = CALC_W'((64'd1 << OUT_WIDTH_P) - 64'd1);

  s1_t s1_in, s1_out;
  s2_t s2_in, s2_out;
  logic s1_valid, s2_ready;
  logic [WIDTH_P:0]       metric;
  logic [OUT_WIDTH_P-1:0] mag;
  logic                   sat;

  // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits, so no wrap.
  always_comb begin
    s1_in        = '0;
    s1_in.a      = WIDTH_P'(abs_val(CALC_W'($signed(bus.gx_i))));
    s1_in.b      = WIDTH_P'(abs_val(CALC_W'($signed(bus.gy_i))));
    s1_in.mode   = bus.mode_i;
    s1_in.thresh = bus.thresh_i;
  end

  elastic_reg #(.W($bits(s1_t))) u_s1 (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .s_tvalid (bus.valid_i),
    .s_tready (bus.ready_o),
    .s_tdata  (s1_in),
    .m_tvalid (s1_valid),
    .m_tready (s2_ready),
    .m_tdata  (s1_out)
  );

  assign metric = (WIDTH_P+1)'(mag_metric(CALC_W'(s1_out.a), CALC_W'(s1_out.b), s1_out.mode));
  assign sat    = CALC_W'(metric) > MAG_MAX;
  assign mag    = sat ? '1 : OUT_WIDTH_P'(metric);

  always_comb begin
    s2_in           = '0;
    s2_in.mag       = mag;
    s2_in.edge_flag = mag >= s1_out.thresh;
    s2_in.sat       = sat;
  end

  elastic_reg #(.W($bits(s2_t))) u_s2 (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .s_tvalid (s1_valid),
    .s_tready (s2_ready),
    .s_tdata  (s2_in),
    .m_tvalid (bus.valid_o),
    .m_tready (bus.ready_i),
    .m_tdata  (s2_out)
  );

  assign bus.mag_o  = s2_out.mag;
  assign bus.edge_o = s2_out.edge_flag;
  assign bus.sat_o  = s2_out.sat;
endmodule

// File: tb/tb_magnitude_pipe.sv
// tb/tb_magnitude_pipe.sv - self-checking bench for magnitude_pipe (8/8 and 12/10 instances)
module tb_magnitude_pipe;
  import sobel_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mag;
    bit edg;
    bit sat;
  } exp_t;

  magnitude_pipe_if #(.WIDTH_P(8),  .OUT_WIDTH_P(8))  b8 ();
  magnitude_pipe_if #(.WIDTH_P(12), .OUT_WIDTH_P(10)) b12 ();

  magnitude_pipe #(.WIDTH_P(8), .OUT_WIDTH_P(8)) dut8 (
    .clk_i (clk), .rstn_i (rstn), .bus (b8)
  );
  magnitude_pipe #(.WIDTH_P(12), .OUT_WIDTH_P(10)) dut12 (
    .clk_i (clk), .rstn_i (rstn), .bus (b12)
  );

  function automatic exp_t model(int gx, int gy, int mode, int thresh, int out_w);
    int a, b, mx, mn, m, top;
    exp_t e;
    a  = (gx < 0) ? -gx : gx;
    b  = (gy < 0) ? -gy : gy;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    case (mode)
      1:       m = mx;
      2:       m = mx + mn / 4 + mn / 8;
      default: m = a + b;
    endcase
    top   = (1 << out_w) - 1;
    e.sat = (m > top);
    e.mag = e.sat ? top : m;
    e.edg = (e.mag >= thresh);
    return e;
  endfunction

  task automatic idle_all();
    b8.valid_i = 0;  b8.gx_i = '0;  b8.gy_i = '0;  b8.mode_i = MAG_L1;  b8.thresh_i = '0;  b8.ready_i = 1;
    b12.valid_i = 0; b12.gx_i = '0; b12.gy_i = '0; b12.mode_i = MAG_L1; b12.thresh_i = '0; b12.ready_i = 1;
  endtask

  task automatic test_reset();
    idle_all();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    checks++;
    if ({b8.valid_o, b8.mag_o, b8.edge_o, b8.sat_o, b8.ready_o} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset8 got v=%b mag=%0d e=%b s=%b rdy=%b want v=0 mag=0 e=0 s=0 rdy=1",
               b8.valid_o, b8.mag_o, b8.edge_o, b8.sat_o, b8.ready_o);
    end
    checks++;
    if ({b12.valid_o, b12.mag_o, b12.ready_o} !== {1'b0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset12 got v=%b mag=%0d rdy=%b want v=0 mag=0 rdy=1", b12.valid_o, b12.mag_o, b12.ready_o);
    end
  endtask

  task automatic send_one8(input int gx, input int gy, input mag_mode_e mode, input int thresh,
                           input int wmag, input bit wedge, input bit wsat, input string name);
    @(posedge clk); #1;
    b8.valid_i = 1; b8.gx_i = 8'(gx); b8.gy_i = 8'(gy); b8.mode_i = mode; b8.thresh_i = 8'(thresh);
    b8.ready_i = 1;
    @(posedge clk); #1;
    b8.valid_i = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b8.valid_o, b8.mag_o, b8.edge_o, b8.sat_o} !== {1'b1, 8'(wmag), wedge, wsat}) begin
      errors++;
      $display("FAIL %s got v=%b mag=%0d e=%b s=%b want v=1 mag=%0d e=%b s=%b",
               name, b8.valid_o, b8.mag_o, b8.edge_o, b8.sat_o, wmag, wedge, wsat);
    end
  endtask

  task automatic test_metrics();
    send_one8(-128,  127, MAG_L1,   200, 255, 1, 0, "l1_max_nosat");
    send_one8(-128, -128, MAG_L1,   200, 255, 1, 1, "l1_sat");
    send_one8(  -3,   10, MAG_LINF,  10,  10, 1, 0, "linf");
    send_one8( 100,  -40, MAG_AL2,  200, 115, 0, 0, "al2");
    send_one8(   0,    0, MAG_AL2,    0,   0, 1, 0, "al2_zero_thresh0");
    send_one8(   5,   -6, MAG_RSVD,  12,  11, 0, 0, "rsvd_as_l1");
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0;
    bit saw_stall = 0, stalled = 0;
    logic [7:0] pmag = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      b8.ready_i = !(c >= 2 && c <= 6);
      b8.valid_i = (sent < 6);
      b8.gx_i = 8'(sent + 1); b8.gy_i = '0; b8.mode_i = MAG_L1; b8.thresh_i = '0;
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (b8.valid_o !== 1'b1 || b8.mag_o !== pmag) begin
          errors++;
          $display("FAIL bp_stable got v=%b mag=%0d want v=1 mag=%0d", b8.valid_o, b8.mag_o, pmag);
        end
      end
      if (b8.ready_o === 1'b0) begin
        saw_stall = 1;
        checks++;
        if (sent - got != 2) begin
          errors++;
          $display("FAIL bp_depth ready_o low with %0d buffered want 2", sent - got);
        end
      end
      if (b8.valid_o && b8.ready_i) begin
        got++;
        checks++;
        if (b8.mag_o !== 8'(got)) begin
          errors++;
          $display("FAIL bp_order got mag=%0d want %0d", b8.mag_o, got);
        end
      end
      if (b8.valid_i && b8.ready_o) sent++;
      stalled = b8.valid_o && !b8.ready_i;
      pmag = b8.mag_o;
    end
    checks++;
    if (got != 6 || !saw_stall) begin
      errors++;
      $display("FAIL bp_count got %0d outputs stall_seen=%0b want 6 outputs stall_seen=1", got, saw_stall);
    end
  endtask

  task automatic test_throughput();
    exp_t q[$];
    exp_t e;
    int gx = 0, gy = 0, md = 0, th = 0;
    for (int c = 0; c < 110; c++) begin
      @(posedge clk); #1;
      b8.ready_i = 1;
      if (c < 100) begin
        gx = $urandom_range(0, 255) - 128; gy = $urandom_range(0, 255) - 128;
        md = $urandom_range(0, 3);          th = $urandom_range(0, 255);
        b8.valid_i = 1; b8.gx_i = 8'(gx); b8.gy_i = 8'(gy);
        b8.mode_i = mag_mode_e'(2'(md)); b8.thresh_i = 8'(th);
      end else begin
        b8.valid_i = 0;
      end
      @(negedge clk);
      if (c < 100) begin
        checks++;
        if (b8.ready_o !== 1'b1) begin
          errors++;
          $display("FAIL tp_ready cycle %0d got ready_o=%b want 1", c, b8.ready_o);
        end
      end
      checks++;
      if (b8.valid_o !== (c >= 2 && c <= 101)) begin
        errors++;
        $display("FAIL tp_valid cycle %0d got valid_o=%b want %0b", c, b8.valid_o, (c >= 2 && c <= 101));
      end
      if (b8.valid_i && b8.ready_o) q.push_back(model(gx, gy, md, th, 8));
      if (b8.valid_o && b8.ready_i && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (b8.mag_o !== 8'(e.mag) || b8.edge_o !== e.edg || b8.sat_o !== e.sat) begin
          errors++;
          $display("FAIL tp_data got mag=%0d e=%b s=%b want mag=%0d e=%b s=%b",
                   b8.mag_o, b8.edge_o, b8.sat_o, e.mag, e.edg, e.sat);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL tp_drain got %0d beats missing want 0", q.size());
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    b8.ready_i = 1; b8.valid_i = 1; b8.gx_i = 8'd7; b8.gy_i = '0; b8.mode_i = MAG_L1; b8.thresh_i = '0;
    @(posedge clk); #1;
    b8.gx_i = 8'd9;
    @(posedge clk); #1;
    b8.valid_i = 0;
    rstn = 0;
    @(negedge clk);
    checks++;
    if (b8.valid_o !== 1'b1 || b8.mag_o !== 8'd7) begin
      errors++;
      $display("FAIL rst_pre got v=%b mag=%0d want v=1 mag=7", b8.valid_o, b8.mag_o);
    end
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    checks++;
    if (b8.valid_o !== 1'b0 || b8.mag_o !== 8'd0 || b8.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got v=%b mag=%0d rdy=%b want v=0 mag=0 rdy=1", b8.valid_o, b8.mag_o, b8.ready_o);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (b8.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale cycle %0d got valid_o=%b want 0", c, b8.valid_o);
      end
    end
  endtask

  task automatic test_random12();
    exp_t q[$];
    exp_t e;
    int gx = 0, gy = 0, md = 0, th = 0, outs = 0;
    bit cur_v = 0, took = 0, stalled = 0;
    logic [9:0] pmag = '0;
    logic pedge = 0, psat = 0;
    for (int c = 0; c < 460; c++) begin
      @(posedge clk); #1;
      if (took || !cur_v) begin
        if (c < 400) begin
          cur_v = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 1) == 0) begin
            gx = $urandom_range(0, 4095) - 2048; gy = $urandom_range(0, 4095) - 2048;
          end else begin
            gx = $urandom_range(0, 600) - 300;   gy = $urandom_range(0, 600) - 300;
          end
          if ($urandom_range(0, 15) == 0) gx = -2048;
          md = $urandom_range(0, 3);
          th = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 1023);
        end else begin
          cur_v = 0;
        end
      end
      b12.valid_i = cur_v; b12.gx_i = 12'(gx); b12.gy_i = 12'(gy);
      b12.mode_i = mag_mode_e'(2'(md)); b12.thresh_i = 10'(th);
      b12.ready_i = (c >= 400) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (b12.valid_o !== 1'b1 || b12.mag_o !== pmag || b12.edge_o !== pedge || b12.sat_o !== psat) begin
          errors++;
          $display("FAIL r12_stable got v=%b mag=%0d e=%b s=%b want v=1 mag=%0d e=%b s=%b",
                   b12.valid_o, b12.mag_o, b12.edge_o, b12.sat_o, pmag, pedge, psat);
        end
      end
      took = b12.valid_i && b12.ready_o;
      if (took) q.push_back(model(gx, gy, md, th, 10));
      if (b12.valid_o && b12.ready_i) begin
        outs++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL r12_extra got output mag=%0d want none", b12.mag_o);
        end else begin
          e = q.pop_front();
          if (b12.mag_o !== 10'(e.mag) || b12.edge_o !== e.edg || b12.sat_o !== e.sat) begin
            errors++;
            $display("FAIL r12_data got mag=%0d e=%b s=%b want mag=%0d e=%b s=%b",
                     b12.mag_o, b12.edge_o, b12.sat_o, e.mag, e.edg, e.sat);
          end
        end
      end
      stalled = b12.valid_o && !b12.ready_i;
      pmag = b12.mag_o; pedge = b12.edge_o; psat = b12.sat_o;
    end
    checks++;
    if (q.size() != 0 || outs == 0) begin
      errors++;
      $display("FAIL r12_drain got %0d pending %0d outputs want 0 pending", q.size(), outs);
    end
  endtask

  initial begin
    test_reset();
    test_metrics();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    test_random12();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
